// File: rtl/ctrl_sel_pkg.sv
// rtl/ctrl_sel_pkg.sv - shared types and constants for the ctrl_sel front-end controller
//
// Contents:
//   state_t   FSM states IDLE, START, WAIT, SHOW
//   ERR_CODE  value shown on data_2 when a run times out
package ctrl_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam logic [15:0] ERR_CODE = 16'hEEEE;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debouncer and rising-edge detector for one raw button
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   btn    in   raw, asynchronous button level
//   level  out  debounced level
//   pulse  out  one-cycle pulse on each rising edge of level
module btn_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_1  <= btn;
      sync_2  <= sync_1;
      level_q <= level;
      pulse   <= level & ~level_q;
      // Only an unbroken run of DEB_CYCLES differing samples flips the level;
      // a single agreeing sample starts the run over.
      if (sync_2 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ctrl_sel.sv
// rtl/ctrl_sel.sv - button-driven program/module selector that launches a module and holds its result
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   btn_prog/mod/run       raw push-buttons
//   mod_data0..3           16-bit result bus of each compute module
//   mod_done[3:0]          done flag per module
//   start                  one-cycle launch pulse to the selected module
//   prog[2:0]              selected program
//   modules[1:0]           selected module
//   data_2[15:0]           held result (ERR_CODE after a timeout)
//   busy                   waiting for the selected module
//   err                    last run timed out
module ctrl_sel
  import ctrl_sel_pkg::*;
#(
  parameter int DEB_CYCLES = 100000,
  parameter int TO_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_prog,
  input  logic        btn_mod,
  input  logic        btn_run,
  input  logic [15:0] mod_data0,
  input  logic [15:0] mod_data1,
  input  logic [15:0] mod_data2,
  input  logic [15:0] mod_data3,
  input  logic [3:0]  mod_done,
  output logic        start,
  output logic [2:0]  prog,
  output logic [1:0]  modules,
  output logic [15:0] data_2,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TO_CYCLES + 1);

  logic p_prog;
  logic p_mod;
  logic p_run;
  // Debounced levels are not needed by the FSM; kept as named nets for probing.
  logic [2:0] levels_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prog (
    .clk(clk), .rst(rst), .btn(btn_prog), .level(levels_unused[0]), .pulse(p_prog)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mod (
    .clk(clk), .rst(rst), .btn(btn_mod), .level(levels_unused[1]), .pulse(p_mod)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst(rst), .btn(btn_run), .level(levels_unused[2]), .pulse(p_run)
  );

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [2:0]    prog_n;
  logic [1:0]    modules_n;
  logic [15:0]   data_n;
  logic          err_n;
  logic          busy_n;
  logic          start_n;
  logic [15:0]   sel_data;
  logic          sel_done;

  always_comb begin
    sel_data = mod_data0;
    case (modules)
      2'd0:    sel_data = mod_data0;
      2'd1:    sel_data = mod_data1;
      2'd2:    sel_data = mod_data2;
      default: sel_data = mod_data3;
    endcase
  end

  assign sel_done = mod_done[modules];

  // Outputs are computed one cycle ahead so every output is a flop:
  // start_n is raised on entry to START, busy_n on entry to WAIT.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    prog_n    = prog;
    modules_n = modules;
    data_n    = data_2;
    err_n     = err;
    busy_n    = 1'b0;
    start_n   = 1'b0;
    case (state)
      IDLE, SHOW: begin
        if (p_run) begin
          state_n = START;
          err_n   = 1'b0;
          start_n = 1'b1;
        end else if (p_mod) begin
          modules_n = modules + 2'd1;
          data_n    = 16'h0000;
          err_n     = 1'b0;
          state_n   = IDLE;
        end else if (p_prog) begin
          prog_n = prog + 3'd1;
        end
      end
      START: begin
        state_n = WAIT;
        cnt_n   = '0;
        busy_n  = 1'b1;
      end
      WAIT: begin
        busy_n = 1'b1;
        if (sel_done) begin
          data_n  = sel_data;
          state_n = SHOW;
          busy_n  = 1'b0;
        end else if (cnt == TW'(TO_CYCLES - 1)) begin
          data_n  = ERR_CODE;
          err_n   = 1'b1;
          state_n = SHOW;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      prog    <= 3'd0;
      modules <= 2'd0;
      data_2  <= 16'h0000;
      err     <= 1'b0;
      busy    <= 1'b0;
      start   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      prog    <= prog_n;
      modules <= modules_n;
      data_2  <= data_n;
      err     <= err_n;
      busy    <= busy_n;
      start   <= start_n;
    end
  end

endmodule

// File: tb/tb_ctrl_sel.sv
// tb/tb_ctrl_sel.sv - directed self-checking bench for ctrl_sel
module tb_ctrl_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_prog, btn_mod, btn_run;
  logic [15:0] mod_data0, mod_data1, mod_data2, mod_data3;
  logic [3:0]  mod_done;
  logic        start;
  logic [2:0]  prog;
  logic [1:0]  modules;
  logic [15:0] data_2;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_sel #(.DEB_CYCLES(4), .TO_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .btn_prog(btn_prog), .btn_mod(btn_mod), .btn_run(btn_run),
    .mod_data0(mod_data0), .mod_data1(mod_data1),
    .mod_data2(mod_data2), .mod_data3(mod_data3),
    .mod_done(mod_done),
    .start(start), .prog(prog), .modules(modules),
    .data_2(data_2), .busy(busy), .err(err)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 = prog, 1 = mod; clean press held well past sync + debounce, then released.
  task automatic press(input int which);
    if (which == 0) btn_prog = 1'b1; else btn_mod = 1'b1;
    step(10);
    if (which == 0) btn_prog = 1'b0; else btn_mod = 1'b0;
    step(10);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
    checks++; if (prog !== 3'd0) begin errors++; $display("FAIL reset_prog: got %0d expected 0", prog); end
    checks++; if (modules !== 2'd0) begin errors++; $display("FAIL reset_modules: got %0d expected 0", modules); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data_2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_prog_wrap;
    for (int i = 0; i < 9; i++) press(0);
    checks++; if (prog !== 3'd1) begin errors++; $display("FAIL prog_wrap: got %0d expected 1", prog); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("FAIL prog_wrap_data: got %h expected 0000", data_2); end
  endtask

  task automatic test_run_glitch;
    int starts;
    bit done_wait;
    starts = 0;
    btn_run = 1'b1;
    btn_mod = 1'b1;
    step(2);
    btn_mod = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (start === 1'b1) starts++;
      step(1);
    end
    btn_run = 1'b0;
    done_wait = 1'b0;
    for (int i = 0; i < 40 && !done_wait; i++) begin
      if (busy === 1'b0) done_wait = 1'b1; else step(1);
    end
    checks++; if (starts != 1) begin errors++; $display("FAIL glitch_start_count: got %0d expected 1", starts); end
    checks++; if (modules !== 2'd0) begin errors++; $display("FAIL glitch_modules: got %0d expected 0", modules); end
    checks++; if (!done_wait) begin errors++; $display("FAIL glitch_busy_timeout: busy still %b expected 0", busy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL glitch_err: got %b expected 1", err); end
    checks++; if (data_2 !== 16'hEEEE) begin errors++; $display("FAIL glitch_data: got %h expected eeee", data_2); end
    step(10);
  endtask

  task automatic test_done_select;
    bit seen;
    press(1);
    press(1);
    checks++; if (modules !== 2'd2) begin errors++; $display("FAIL sel_modules: got %0d expected 2", modules); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sel_err_clear: got %b expected 0", err); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("FAIL sel_data_clear: got %h expected 0000", data_2); end
    btn_run = 1'b1;
    wait_start(seen);
    btn_run = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL sel_start_seen: got 0 expected 1"); end
    mod_data1 = 16'hBEEF;
    mod_done  = 4'b0010;
    step(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sel_busy_first_wait: got %b expected 1", busy); end
    step(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sel_other_done_ignored: busy got %b expected 1", busy); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("FAIL sel_other_data_ignored: got %h expected 0000", data_2); end
    mod_data2 = 16'h1234;
    mod_done  = 4'b0110;
    step(1);
    mod_done = 4'b0000;
    checks++; if (data_2 !== 16'h1234) begin errors++; $display("FAIL sel_data: got %h expected 1234", data_2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sel_busy_drop: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sel_err: got %b expected 0", err); end
    step(10);
  endtask

  task automatic test_timeout;
    bit seen;
    btn_run = 1'b1;
    wait_start(seen);
    btn_run = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL to_start_seen: got 0 expected 1"); end
    step(16);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b expected 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_last_wait: got %b expected 1", busy); end
    step(1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err); end
    checks++; if (data_2 !== 16'hEEEE) begin errors++; $display("FAIL to_data: got %h expected eeee", data_2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
    step(10);
    press(1);
    checks++; if (modules !== 2'd3) begin errors++; $display("FAIL to_mod_after: got %0d expected 3", modules); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("FAIL to_data_clear: got %h expected 0000", data_2); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", err); end
  endtask

  task automatic test_wait_drops;
    bit seen;
    logic [2:0] prog_before;
    prog_before = prog;
    mod_data3 = 16'hCAFE;
    btn_run = 1'b1;
    wait_start(seen);
    btn_run = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL drop_start_seen: got 0 expected 1"); end
    btn_prog = 1'b1;
    step(10);
    btn_prog = 1'b0;
    step(6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_terminal: got %b expected 1", busy); end
    checks++; if (prog !== prog_before) begin errors++; $display("FAIL drop_prog: got %0d expected %0d", prog, prog_before); end
    mod_done = 4'b1000;
    step(1);
    mod_done = 4'b0000;
    checks++; if (data_2 !== 16'hCAFE) begin errors++; $display("FAIL terminal_done_data: got %h expected cafe", data_2); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL terminal_done_err: got %b expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL terminal_done_busy: got %b expected 0", busy); end
    step(10);
    checks++; if (prog !== prog_before) begin errors++; $display("FAIL drop_prog_after: got %0d expected %0d", prog, prog_before); end
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    int starts;
    btn_run = 1'b1;
    wait_start(seen);
    btn_run = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL rstw_start_seen: got 0 expected 1"); end
    step(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b expected 0", busy); end
    checks++; if (prog !== 3'd0) begin errors++; $display("FAIL rstw_prog: got %0d expected 0", prog); end
    checks++; if (modules !== 2'd0) begin errors++; $display("FAIL rstw_modules: got %0d expected 0", modules); end
    checks++; if (data_2 !== 16'h0000) begin errors++; $display("FAIL rstw_data: got %h expected 0000", data_2); end
    checks++; if (err !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL rstw_err_start: got err=%b start=%b expected 0 0", err, start); end
    step(2);
    rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (start === 1'b1) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL rstw_no_start: got %0d pulses expected 0", starts); end
  endtask

  initial begin
    rst = 1'b1;
    btn_prog = 1'b0;
    btn_mod = 1'b0;
    btn_run = 1'b0;
    mod_data0 = 16'h0000;
    mod_data1 = 16'h0000;
    mod_data2 = 16'h0000;
    mod_data3 = 16'h0000;
    mod_done = 4'b0000;
    test_reset();
    test_prog_wrap();
    test_run_glitch();
    test_done_select();
    test_timeout();
    test_wait_drops();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
